// File: rtl/fetch_decode_queue_pkg.sv
// fetch_decode_queue_pkg: shared NOP constant, RV32 field positions and queue entry type.
package fetch_decode_queue_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int FUNCT7_LSB = 25;
    localparam int PC_W_MAX = 64;
    typedef struct packed {
        logic [31:0] instr;
        logic [PC_W_MAX-1:0] pc;
    } instr_entry_t;
endpackage

// File: rtl/fetch_decode_queue_nop_field_select.sv
// nop_field_select: splits an RV32 word into decode fields, substituting the NOP word when killed.
module nop_field_select #(
    parameter logic [31:0] NOP_INSTR = fetch_decode_queue_pkg::NOP_INSTR
) (
    input  logic [31:0] instr,
    input  logic        kill,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [24:0] instr_31_7
);
    import fetch_decode_queue_pkg::*;
    logic [31:0] w;
    always_comb begin
        w = kill ? NOP_INSTR : instr;
        opcode = w[OPCODE_LSB +: 7];
        rd_addr = w[RD_LSB +: 5];
        funct3 = w[FUNCT3_LSB +: 3];
        rs1_addr = w[RS1_LSB +: 5];
        rs2_addr = w[RS2_LSB +: 5];
        funct7 = w[FUNCT7_LSB +: 7];
        instr_31_7 = w[31:RD_LSB];
    end
endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: PC-tagged instruction queue between fetch and decode with flush-to-NOP head.
module fetch_decode_queue #(
    parameter int          DEPTH     = 4,
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = fetch_decode_queue_pkg::NOP_INSTR
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush_in,
    input  logic                       valid_in,
    input  logic [31:0]                instr_in,
    input  logic [PC_W-1:0]            pc_in,
    output logic                       ready_out,
    input  logic                       stall_in,
    output logic                       valid_out,
    output logic [6:0]                 opcode_out,
    output logic [2:0]                 funct3_out,
    output logic [6:0]                 funct7_out,
    output logic [4:0]                 rs1_addr_out,
    output logic [4:0]                 rs2_addr_out,
    output logic [4:0]                 rd_addr_out,
    output logic [24:0]                instr_31_7_out,
    output logic [PC_W-1:0]            pc_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);
    import fetch_decode_queue_pkg::*;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    instr_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic kill, push, pop;
    always_comb begin
        kill = flush_in | (count == '0);
        ready_out = count != CW'(DEPTH);
        valid_out = !kill;
        push = valid_in & ready_out & !flush_in;
        pop = valid_out & !stall_in;
        pc_out = kill ? '0 : mem[rd_ptr].pc[PC_W-1:0];
        count_out = count;
    end
    nop_field_select #(.NOP_INSTR(NOP_INSTR)) u_sel (
        .instr(mem[rd_ptr].instr),
        .kill(kill),
        .opcode(opcode_out),
        .funct3(funct3_out),
        .funct7(funct7_out),
        .rs1_addr(rs1_addr_out),
        .rs2_addr(rs2_addr_out),
        .rd_addr(rd_addr_out),
        .instr_31_7(instr_31_7_out)
    );
    // Pointers wrap for free since DEPTH is a power of two; entry contents survive a flush.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{instr: instr_in, pc: PC_W_MAX'(pc_in)};
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assert property (@(posedge clk_in) disable iff (rst_in) count <= CW'(DEPTH));
    assert property (@(posedge clk_in) disable iff (rst_in) !(pop && count == '0));
    assert property (@(posedge clk_in) disable iff (rst_in) !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed stimulus with a scoreboard of accepted entries checked at the head.
module tb_fetch_decode_queue;
    logic clk_in = 0, rst_in = 1, flush_in = 0, valid_in = 0, stall_in = 0;
    logic [31:0] instr_in = '0, pc_in = '0;
    logic ready_out, valid_out;
    logic [6:0] opcode_out, funct7_out;
    logic [2:0] funct3_out;
    logic [4:0] rs1_addr_out, rs2_addr_out, rd_addr_out;
    logic [24:0] instr_31_7_out;
    logic [31:0] pc_out;
    logic [2:0] count_out;
    int total = 0, bad = 0, npop = 0;
    logic [63:0] sb[$];

    fetch_decode_queue #(.DEPTH(4), .PC_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .valid_in(valid_in),
        .instr_in(instr_in), .pc_in(pc_in), .ready_out(ready_out), .stall_in(stall_in),
        .valid_out(valid_out), .opcode_out(opcode_out), .funct3_out(funct3_out),
        .funct7_out(funct7_out), .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out),
        .rd_addr_out(rd_addr_out), .instr_31_7_out(instr_31_7_out), .pc_out(pc_out),
        .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        valid_in = 1;
        instr_in = i;
        pc_in = p;
        step();
        valid_in = 0;
    endtask

    task automatic chk_reset();
        @(negedge clk_in);
        chk("rst count", 64'(count_out), 0);
        chk("rst ready", 64'(ready_out), 1);
        chk("rst valid", 64'(valid_out), 0);
        chk("rst opcode", 64'(opcode_out), 64'h13);
        chk("rst funct3", 64'(funct3_out), 0);
        chk("rst funct7", 64'(funct7_out), 0);
        chk("rst rs1", 64'(rs1_addr_out), 0);
        chk("rst rs2", 64'(rs2_addr_out), 0);
        chk("rst rd", 64'(rd_addr_out), 0);
        chk("rst imm", 64'(instr_31_7_out), 0);
        chk("rst pc", 64'(pc_out), 0);
    endtask

    function automatic logic [31:0] mk(input int i);
        return {7'(i), 5'(i + 1), 5'(i + 2), 3'(i), 5'(i + 3), 7'h33};
    endfunction

    // Expected entries enter the scoreboard on the cycle the handshake completes.
    initial forever begin
        @(negedge clk_in);
        if (valid_in && ready_out && !flush_in && !rst_in) sb.push_back({instr_in, pc_in});
    end

    initial forever begin
        logic [31:0] ei;
        @(negedge clk_in);
        if (rst_in) sb.delete();
        else if (flush_in) begin
            chk("flush valid", 64'(valid_out), 0);
            chk("flush opcode", 64'(opcode_out), 64'h13);
            chk("flush pc", 64'(pc_out), 0);
            sb.delete();
        end else if (valid_out) begin
            if (sb.size() == 0) chk("unexpected head pc", 64'(pc_out), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                ei = sb[0][63:32];
                chk("head fields", 64'({funct7_out, rs2_addr_out, rs1_addr_out, funct3_out, rd_addr_out, opcode_out}), 64'(ei));
                chk("head imm", 64'(instr_31_7_out), 64'(ei[31:7]));
                chk("head pc", 64'(pc_out), 64'(sb[0][31:0]));
                if (!stall_in) begin
                    void'(sb.pop_front());
                    npop++;
                end
            end
        end else begin
            chk("idle opcode", 64'(opcode_out), 64'h13);
            chk("idle pc", 64'(pc_out), 0);
        end
    end

    initial begin
        repeat (2) @(posedge clk_in);
        #1 rst_in = 0;
        chk_reset();
        step();
        push(32'h00A0_0093, 32'h100);
        @(negedge clk_in);
        chk("t2 valid", 64'(valid_out), 1);
        chk("t2 opcode", 64'(opcode_out), 64'h13);
        chk("t2 rd", 64'(rd_addr_out), 1);
        chk("t2 imm", 64'(instr_31_7_out), 64'h0014001);
        chk("t2 pc", 64'(pc_out), 64'h100);
        chk("t2 count", 64'(count_out), 1);
        step();
        @(negedge clk_in);
        chk("t2 drained", 64'(count_out), 0);
        step();
        stall_in = 1;
        for (int i = 0; i < 4; i++) push(mk(i), 32'(4 * i));
        valid_in = 1;
        instr_in = mk(4);
        pc_in = 32'h10;
        @(negedge clk_in);
        chk("full count", 64'(count_out), 4);
        chk("full ready", 64'(ready_out), 0);
        step();
        @(negedge clk_in);
        chk("held count", 64'(count_out), 4);
        chk("held pc", 64'(pc_out), 0);
        step();
        stall_in = 0;
        step();
        @(negedge clk_in);
        chk("release count", 64'(count_out), 3);
        chk("release ready", 64'(ready_out), 1);
        step();
        valid_in = 0;
        repeat (5) step();
        @(negedge clk_in);
        chk("t3 count", 64'(count_out), 0);
        chk("t3 pops", 64'(npop), 6);
        step();
        stall_in = 1;
        for (int i = 0; i < 3; i++) push(mk(10 + i), 32'h20 + 32'(4 * i));
        @(negedge clk_in);
        chk("pre flush count", 64'(count_out), 3);
        step();
        flush_in = 1;
        stall_in = 0;
        valid_in = 1;
        instr_in = mk(13);
        pc_in = 32'h2C;
        @(negedge clk_in);
        chk("flush rd", 64'(rd_addr_out), 0);
        chk("flush ready", 64'(ready_out), 1);
        step();
        flush_in = 0;
        valid_in = 0;
        @(negedge clk_in);
        chk("post flush count", 64'(count_out), 0);
        chk("post flush valid", 64'(valid_out), 0);
        step();
        stall_in = 1;
        push(mk(20), 32'h40);
        push(mk(21), 32'h44);
        stall_in = 0;
        for (int i = 0; i < 6; i++) begin
            valid_in = 1;
            instr_in = mk(22 + i);
            pc_in = 32'h48 + 32'(4 * i);
            @(negedge clk_in);
            chk("steady count", 64'(count_out), 2);
            step();
        end
        valid_in = 0;
        repeat (3) step();
        @(negedge clk_in);
        chk("t5 count", 64'(count_out), 0);
        step();
        stall_in = 1;
        for (int i = 0; i < 3; i++) push(mk(30 + i), 32'h60 + 32'(4 * i));
        @(negedge clk_in);
        chk("pre rst count", 64'(count_out), 3);
        step();
        rst_in = 1;
        step();
        rst_in = 0;
        chk_reset();
        step();
        stall_in = 0;
        push(32'h0010_0113, 32'h200);
        @(negedge clk_in);
        chk("post rst valid", 64'(valid_out), 1);
        chk("post rst pc", 64'(pc_out), 64'h200);
        step();
        @(negedge clk_in);
        chk("final count", 64'(count_out), 0);
        chk("final pops", 64'(npop), 15);
        chk("sb empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
